fifo_write_ctrl: RTL and testbench

Write-side control stage that sits directly upstream of the 16x8 FIFO register bank and drives that bank's write address and write enable. It keeps the binary and Gray-coded write pointers. It brings the read-domain Gray pointer into the write clock domain through a synchronizer and generates the registered full flag. Write requests made while full are dropped and reported.

---
 rtl/fifo_write_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_write_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side control for a 2**ADDR_W entry FIFO register bank.
// Keeps the binary and Gray write pointers, synchronises the read-domain Gray
// pointer into this clock domain, and produces the registered full and
// overflow flags. Requests that arrive while full are dropped and reported
// with a one-cycle overflow pulse.
//
// Optional feature: define ALMOST_FULL_EN to add the registered almost_full
// output, which asserts when occupancy (against the synchronised read
// pointer) reaches AF_THRESH. Without the macro, that port and its
// subtract/Gray-decode logic do not exist.
//
// SYNC_STAGES is expected to be 2 or 3.

module fifo_write_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
`ifdef ALMOST_FULL_EN
  ,
  parameter int AF_THRESH   = 12
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_gray_i,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wr_gray_o,
  output logic              full,
  output logic              overflow
`ifdef ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  // Pointer state
  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;

  // Read-pointer synchroniser chain; the last stage is the usable copy
  logic [SYNC_STAGES-1:0][ADDR_W:0] r_sync;

  // Flags
  logic r_full;
  logic r_overflow;

  // Next-state helpers
  logic            w_wen;
  logic [ADDR_W:0] w_wbin_next;
  logic [ADDR_W:0] w_wgray_next;
  logic [ADDR_W:0] w_rq_gray;
  logic [ADDR_W:0] w_full_gray;

  // A write is accepted whenever asked and there is room; reset blocks it
  // combinationally so the bank never sees a write during reset.
  assign w_wen        = wr_req & ~r_full & ~rst;
  assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wen};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  assign w_rq_gray    = r_sync[SYNC_STAGES-1];

  // Full in Gray space: the write pointer equals the read pointer with its
  // two MSBs inverted, i.e. exactly one lap (2**ADDR_W entries) ahead.
  assign w_full_gray  = {~w_rq_gray[ADDR_W:ADDR_W-1], w_rq_gray[ADDR_W-2:0]};

  // Advance the binary and Gray write pointers on every accepted write
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else if (w_wen) begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
    end
  end

  // Bring the asynchronous read Gray pointer through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= rd_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Register full against the post-write pointer, and flag dropped requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_full     <= (w_wgray_next == w_full_gray);
      r_overflow <= wr_req & r_full;
    end
  end

`ifdef ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_LIM = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W:0] w_rq_bin;
  logic [ADDR_W:0] w_occupancy;
  logic            r_almost_full;

  // Decode the synchronised Gray read pointer back to binary
  always_comb begin
    // NOTE: every bit gets a default before the loop so no latch can form.
    w_rq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_rq_bin[i] = ^(w_rq_gray >> i);
    end
  end

  // Occupancy wraps naturally in ADDR_W+1 bits
  assign w_occupancy = w_wbin_next - w_rq_bin;

  // Register the almost-full threshold comparison
  always_ff @(posedge clk) begin
    if (rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_occupancy >= AF_LIM);
    end
  end

  assign almost_full = r_almost_full;
`endif

  assign wen       = w_wen;
  assign waddr     = r_wbin[ADDR_W-1:0];
  assign wr_gray_o = r_wgray;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl. Expected values come from an
// occupancy-count model: writes and reads are plain counters, the read count
// reaches the write side SYNC_STAGES edges late, and full/almost_full follow
// from the occupancy number.

module tb_fifo_write_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AF    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW:0]   rd_gray_i;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wr_gray_o;
  logic          full;
  logic          overflow;
`ifdef ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_write_ctrl #(
    .ADDR_W      (AW),
    .SYNC_STAGES (SS)
`ifdef ALMOST_FULL_EN
    ,
    .AF_THRESH   (AF)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_gray_i   (rd_gray_i),
    .wen         (wen),
    .waddr       (waddr),
    .wr_gray_o   (wr_gray_o),
    .full        (full),
    .overflow    (overflow)
`ifdef ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_wr = 0;     // accepted writes, mod 2*DEPTH
  int m_rd = 0;     // read count currently presented on rd_gray_i
  int m_q[$];       // read counts in flight to the write side
  bit m_full = 0;
  bit m_ovf  = 0;
  bit m_af   = 0;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = AW'(0) + (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit req, input int rd);
    wr_req    = req;
    m_rd      = rd % PMOD;
    rd_gray_i = gray(m_rd);
  endtask

  // One clock: check combinational outputs mid-cycle, take the edge, advance
  // the model, then check registered outputs 1 ns after the edge.
  task automatic cycle(input string tag, input bit pre);
    int rq;
    int occ;
    bit acc;
    #3;
    if (pre) begin
      check({tag, ".wen"},   32'(wen),   32'(wr_req && !m_full && !rst));
      check({tag, ".waddr"}, 32'(waddr), 32'(m_wr % DEPTH));
    end
    @(posedge clk);
    if (rst) begin
      m_wr   = 0;
      m_full = 0;
      m_ovf  = 0;
      m_af   = 0;
      m_q.delete();
      for (int i = 0; i < SS; i++) m_q.push_back(0);
    end else begin
      rq     = m_q[0];
      acc    = wr_req && !m_full;
      m_ovf  = wr_req && m_full;
      m_wr   = (m_wr + int'(acc)) % PMOD;
      occ    = (m_wr - rq + PMOD) % PMOD;
      m_full = (occ == DEPTH);
      m_af   = (occ >= AF);
      void'(m_q.pop_front());
      m_q.push_back(m_rd);
    end
    #1;
    check({tag, ".full"},  32'(full),      32'(m_full));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, ".gray"},  32'(wr_gray_o), 32'(gray(m_wr)));
    check({tag, ".waddr"}, 32'(waddr),     32'(m_wr % DEPTH));
`ifdef ALMOST_FULL_EN
    check({tag, ".af"},    32'(almost_full), 32'(m_af));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW:0]   prev_g;
    logic [AW-1:0] prev_a;
    int  acc_n;
    int  cyc_n;
    bit  gray_ok;
    bit  saw_10000;
    bit  saw_00000;
    bit  wrapped;
    bit  full_seen;

    // Reset for two cycles with a request pending
    rst = 1'b1;
    set_in(1, 0);
    #1;
    check("rst.wen", 32'(wen), 32'(0));
    cycle("rst0", 1'b0);
    cycle("rst1", 1'b1);
    check("rst.gray0", 32'(wr_gray_o), 32'(0));
    check("rst.full0", 32'(full), 32'(0));

    // Fill: 16 back-to-back writes with the read pointer parked at 0
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0);
      cycle("fill", 1'b1);
    end
    check("fill.full",  32'(full),      32'(1));
    check("fill.gray",  32'(wr_gray_o), 32'(5'b11000));
    check("fill.waddr", 32'(waddr),     32'(0));

    // Overflow: three requests while full are dropped
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0);
      #2;
      check("ovf.wen", 32'(wen), 32'(0));
      cycle("ovf", 1'b1);
      check("ovf.pulse", 32'(overflow),  32'(1));
      check("ovf.gray",  32'(wr_gray_o), 32'(5'b11000));
    end
    set_in(0, 0);
    cycle("ovf_end", 1'b1);
    check("ovf.clear", 32'(overflow), 32'(0));

    // Drain release: one read; full clears on the third edge
    set_in(0, 1);
    cycle("drain1", 1'b1);
    check("drain.e1", 32'(full), 32'(1));
    cycle("drain2", 1'b1);
    check("drain.e2", 32'(full), 32'(1));
    cycle("drain3", 1'b1);
    check("drain.e3", 32'(full), 32'(0));
    set_in(1, 1);
    #2;
    check("drain.wen",   32'(wen),   32'(1));
    check("drain.waddr", 32'(waddr), 32'(0));
    cycle("drain_wr", 1'b1);
    check("drain.refull", 32'(full), 32'(1));

    // Wrap: reads trail writes by two; settle first, then 40 writes
    for (int i = 0; i < 4; i++) begin
      set_in(0, m_wr + PMOD - 2);
      cycle("wrap_settle", 1'b1);
    end
    acc_n = 0; cyc_n = 0; gray_ok = 1; saw_10000 = 0; saw_00000 = 0;
    wrapped = 0; full_seen = 0;
    while (acc_n < 40 && cyc_n < 200) begin
      set_in(1, m_wr + PMOD - 2);
      prev_g = wr_gray_o;
      prev_a = waddr;
      cycle("wrap", 1'b1);
      cyc_n++;
      if (full) full_seen = 1;
      if (wr_gray_o !== prev_g) begin
        acc_n++;
        if ($countones(prev_g ^ wr_gray_o) != 1) gray_ok = 0;
        if (wr_gray_o == 5'b10000) saw_10000 = 1;
        if (wr_gray_o == 5'b00000) saw_00000 = 1;
        if (prev_a == 4'd15 && waddr == 4'd0) wrapped = 1;
      end
    end
    check("wrap.count",   32'(acc_n),     32'(40));
    check("wrap.grayok",  32'(gray_ok),   32'(1));
    check("wrap.g10000",  32'(saw_10000), 32'(1));
    check("wrap.g00000",  32'(saw_00000), 32'(1));
    check("wrap.addr",    32'(wrapped),   32'(1));
    check("wrap.nofull",  32'(full_seen), 32'(0));

    // Random traffic: reads advance only while something is stored
    for (int i = 0; i < 300; i++) begin
      if ((m_wr - m_rd + PMOD) % PMOD > 0 && $urandom_range(0, 2) == 0)
        set_in(1'($urandom_range(0, 1)), m_rd + 1);
      else
        set_in(1'($urandom_range(0, 1)), m_rd);
      cycle("rand", 1'b1);
    end

    // Reset mid-fill: 7 writes, then one reset cycle with a request pending
    rst = 1'b1;
    set_in(0, 0);
    cycle("mr_rst", 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0);
      cycle("mr_fill", 1'b1);
    end
    check("mr.waddr7", 32'(waddr), 32'(7));
    rst = 1'b1;
    set_in(1, 0);
    #2;
    check("mr.wen", 32'(wen), 32'(0));
    cycle("mr_hit", 1'b1);
    check("mr.waddr", 32'(waddr),     32'(0));
    check("mr.gray",  32'(wr_gray_o), 32'(0));
    check("mr.full",  32'(full),      32'(0));
    check("mr.ovf",   32'(overflow),  32'(0));
    rst = 1'b0;

`ifdef ALMOST_FULL_EN
    // Almost-full threshold with the read pointer at 0
    for (int i = 0; i < AF - 1; i++) begin
      set_in(1, 0);
      cycle("af_fill", 1'b1);
    end
    check("af.at11", 32'(almost_full), 32'(0));
    set_in(1, 0);
    cycle("af_12", 1'b1);
    check("af.at12", 32'(almost_full), 32'(1));
    set_in(0, 2);
    cycle("af_d1", 1'b1);
    check("af.e1", 32'(almost_full), 32'(1));
    cycle("af_d2", 1'b1);
    check("af.e2", 32'(almost_full), 32'(1));
    cycle("af_d3", 1'b1);
    check("af.e3", 32'(almost_full), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
